// File: rtl/sram_mem_pkg.sv
// rtl/sram_mem_pkg.sv - shared FSM state type and default parameters for the SRAM memory stage
package sram_mem_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_SRAM_DW   = 16;
  localparam int DEF_SRAM_AW   = 18;
  localparam int DEF_WAIT_CYC  = 5;
  localparam int DEF_WB_DEPTH  = 4;
  localparam int DEF_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - synchronous FIFO holding posted {address, data} stores
module mem_write_buffer #(
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = slots[rd_ptr_q];
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/sram_mem_stage.sv
// rtl/sram_mem_stage.sv - pipeline memory stage with posted write buffer over a multi-beat async SRAM
module sram_mem_stage
  import sram_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SRAM_DW   = DEF_SRAM_DW,
  parameter int SRAM_AW   = DEF_SRAM_AW,
  parameter int WAIT_CYC  = DEF_WAIT_CYC,
  parameter int WB_DEPTH  = DEF_WB_DEPTH,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEMread,
  input  logic               MEMwrite,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  MEM_result,
  output logic               freeze,
  output logic               wb_empty,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W  = $clog2(WAIT_CYC);
  localparam int OFF_SH  = $clog2(DATA_W / 8);
  localparam int ENTRY_W = 32 + DATA_W;
  localparam int CNT_W   = $clog2(WB_DEPTH) + 1;

  mem_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, result_q, result_d;
  logic                do_load, do_store, wb_push, wb_pop, wb_full, wb_is_empty;
  logic [CNT_W-1:0]    wb_count;
  logic [ENTRY_W-1:0]  wb_head;
  logic [31:0]         head_addr, acc_addr, word_idx;
  logic [DATA_W-1:0]   head_wdata;
  logic                beat_end, last_beat, dq_oe;

  // A simultaneous load and store is treated as a load only.
  assign do_load  = MEMread;
  assign do_store = MEMwrite & ~MEMread;
  assign wb_push  = do_store & ~wb_full;

  mem_write_buffer #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (WB_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .push_data ({address, data}),
    .pop       (wb_pop),
    .head_data (wb_head),
    .full      (wb_full),
    .empty     (wb_is_empty),
    .count     (wb_count)
  );

  assign {head_addr, head_wdata} = wb_head;
  assign beat_end  = (wait_q == WAIT_W'(WAIT_CYC - 1));
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    result_d  = result_q;
    wb_pop    = 1'b0;
    dq_oe     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    freeze    = 1'b0;
    if (do_load)       freeze = (state_q != ST_DONE);
    else if (do_store) freeze = wb_full;

    case (state_q)
      ST_IDLE: begin
        if (!wb_is_empty)  state_d = ST_WRITE;
        else if (do_load)  state_d = ST_READ;
      end
      ST_WRITE: begin
        dq_oe     = 1'b1;
        SRAM_WE_N = beat_end;
        wait_d    = wait_q + WAIT_W'(1);
        if (beat_end) begin
          wait_d = '0;
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            wb_pop  = 1'b1;
            state_d = ((wb_count > CNT_W'(1)) || wb_push) ? ST_WRITE : ST_IDLE;
          end
        end
      end
      ST_READ: begin
        SRAM_OE_N = 1'b0;
        wait_d    = wait_q + WAIT_W'(1);
        if (beat_end) begin
          rdata_d[beat_q*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          wait_d = '0;
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d   = '0;
            result_d = rdata_d;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      rdata_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      result_q <= result_d;
    end
  end

  // Writes address from the buffer head; loads use the pipeline's held address.
  assign acc_addr  = (state_q == ST_WRITE) ? head_addr : address;
  assign word_idx  = (acc_addr - 32'(BASE_ADDR)) >> OFF_SH;
  assign SRAM_ADDR = SRAM_AW'(word_idx * 32'(BEATS) + 32'(beat_q));
  assign SRAM_DQ   = dq_oe ? head_wdata[beat_q*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};

  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign MEM_result = result_q;
  assign wb_empty   = wb_is_empty && (state_q != ST_WRITE);

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb/tb_sram_mem_stage.sv - directed vector bench for sram_mem_stage with a behavioural SRAM
module tb_sram_mem_stage;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, MEMread, MEMwrite;
  logic [31:0]   address;
  logic [DW-1:0] data, mem_result;
  logic          freeze, wb_empty;
  wire  [15:0]   sram_dq;
  logic [17:0]   sram_addr;
  logic          ub_n, lb_n, we_n, ce_n, oe_n;

  sram_mem_stage dut (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite), .address(address), .data(data),
    .MEM_result(mem_result), .freeze(freeze), .wb_empty(wb_empty), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  logic        rd64;
  logic [31:0] addr64;
  logic [63:0] res64;
  logic        frz64, wbe64;
  wire  [15:0] dq64;
  logic [17:0] sa64;
  logic        ub64, lb64, we64, ce64, oe64;

  sram_mem_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .MEMread(rd64), .MEMwrite(1'b0), .address(addr64), .data(64'h0),
    .MEM_result(res64), .freeze(frz64), .wb_empty(wbe64), .SRAM_DQ(dq64),
    .SRAM_ADDR(sa64), .SRAM_UB_N(ub64), .SRAM_LB_N(lb64), .SRAM_WE_N(we64),
    .SRAM_CE_N(ce64), .SRAM_OE_N(oe64)
  );

  assign dq64 = !oe64 ? 16'(18'h01000 + sa64) : 16'hzzzz;

  logic [15:0] sram [0:(1<<18)-1];
  logic        init_mem = 1'b0;
  logic        prev_we_n = 1'b1;
  int          wlog[$];

  assign sram_dq = !oe_n ? sram[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    prev_we_n <= we_n;
    if (init_mem) begin
      sram[0] <= 16'h5678;
      sram[1] <= 16'h1234;
      for (int i = 2; i < 32; i++) sram[i] <= 16'h0;
    end else if (!we_n) begin
      sram[sram_addr] <= sram_dq;
    end
    if (!we_n && prev_we_n) wlog.push_back(int'(sram_addr));
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [DW-1:0] d, output int fcyc, output logic [DW-1:0] res);
    MEMread = rd; MEMwrite = wr; address = a; data = d; fcyc = 0;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      fcyc++;
      if (fcyc > 300) begin
        total++; bad++;
        $display("FAIL op_timeout: freeze stuck at addr %0h", a);
        break;
      end
      @(posedge clk); #1;
    end
    res = mem_result;
    @(posedge clk); #1;
    MEMread = 1'b0; MEMwrite = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    @(negedge clk);
    while (!wb_empty && n < 300) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_res;
    int          exp_fcyc;
    logic        drain;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, n, base;
    logic [DW-1:0] res;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678, 11, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0,        0,  1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h0,        0,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEF00D, 22, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'h11111111, 32'hDEADBEEF, 11, 1'b0};

    rst = 1'b1; MEMread = 1'b0; MEMwrite = 1'b0; address = '0; data = '0;
    rd64 = 1'b0; addr64 = '0; init_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    chk("rst_freeze", 64'(freeze), 64'd0);
    chk("rst_wb_empty", 64'(wb_empty), 64'd1);
    chk("rst_result", 64'(mem_result), 64'd0);
    chk("rst_we_n", 64'(we_n), 64'd1);
    chk("rst_oe_n", 64'(oe_n), 64'd1);
    chk("tied_ce_ub_lb", {61'd0, ce_n, ub_n, lb_n}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, fc, res);
      chk($sformatf("v%0d_freeze_cycles", i), 64'(fc), 64'(vecs[i].exp_fcyc));
      if (vecs[i].rd) chk($sformatf("v%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
      if (vecs[i].drain) begin
        wait_drain(n);
        chk($sformatf("v%0d_drain_cycles", i), 64'(n), 64'd11);
      end
    end
    @(negedge clk);
    chk("load_and_store_no_enqueue", 64'(wb_empty), 64'd1);
    @(posedge clk); #1;

    base = wlog.size();
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, 1'b1, 32'd1036 + 32'(4*k), {16'hA000 + 16'(k), 16'hB000 + 16'(k)}, fc, res);
      chk($sformatf("burst%0d_freeze_cycles", k), 64'(fc), (k == 4) ? 64'd8 : 64'd0);
    end
    wait_drain(n);
    chk("burst_drain_cycles", 64'(n), 64'd39);
    chk("burst_beat_count", 64'(wlog.size() - base), 64'd10);
    for (int j = 0; j < 10; j++)
      chk($sformatf("burst_order%0d", j),
          64'((base + j < wlog.size()) ? wlog[base + j] : -1), 64'(6 + j));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("burst_lo%0d", k), 64'(sram[6 + 2*k]), 64'(16'hB000 + 16'(k)));
      chk($sformatf("burst_hi%0d", k), 64'(sram[7 + 2*k]), 64'(16'hA000 + 16'(k)));
    end
    chk("sram_hw2", 64'(sram[2]), 64'hBEEF);
    chk("sram_hw3", 64'(sram[3]), 64'hDEAD);
    chk("sram_hw4", 64'(sram[4]), 64'hF00D);
    chk("sram_hw5", 64'(sram[5]), 64'hCAFE);

    // Reset during the second beat of a load.
    MEMread = 1'b1; address = 32'd1024;
    repeat (7) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("read_active_before_rst", 64'(oe_n), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; MEMread = 1'b0;
    @(negedge clk);
    chk("rst_read_oe_n", 64'(oe_n), 64'd1);
    chk("rst_read_result", 64'(mem_result), 64'd0);
    chk("rst_read_wb_empty", 64'(wb_empty), 64'd1);
    chk("rst_read_freeze", 64'(freeze), 64'd0);
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'd1024, '0, fc, res);
    chk("reload_freeze_cycles", 64'(fc), 64'd11);
    chk("reload_result", 64'(res), 64'h12345678);

    // Reset during a write discards the buffered stores.
    run_op(1'b0, 1'b1, 32'd1060, 32'h22221111, fc, res);
    run_op(1'b0, 1'b1, 32'd1064, 32'h44443333, fc, res);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_write_wb_empty", 64'(wb_empty), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_write_hw19", 64'(sram[19]), 64'd0);
    chk("rst_write_hw20", 64'(sram[20]), 64'd0);
    chk("rst_write_hw21", 64'(sram[21]), 64'd0);

    // 64-bit data path: four halfwords per word.
    rd64 = 1'b1; addr64 = 32'd1032; fc = 0;
    forever begin
      @(negedge clk);
      if (!frz64) break;
      fc++;
      if (fc > 300) begin
        total++; bad++;
        $display("FAIL w64_timeout: freeze stuck");
        break;
      end
      @(posedge clk); #1;
    end
    chk("w64_freeze_cycles", 64'(fc), 64'd21);
    chk("w64_result", res64, 64'h1007_1006_1005_1004);
    @(posedge clk); #1;
    rd64 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
